// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
//   Display back-end for the FND counter IP. A 14-bit binary value is turned
//   into four BCD digits by a sequential double-dabble converter, then the
//   digits are time-multiplexed onto a 4-digit common-anode 7-segment display.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   i_en        display enable (blank when low, scanning keeps running)
//   i_blank_lz  leading-zero blanking enable
//   i_value     binary value to display
//   i_dp        decimal-point enables, bit n = digit n
//   o_fnd_com   digit commons, active-low, bit 0 = ones digit
//   o_fnd_data  segments, active-low, {dp,g,f,e,d,c,b,a}
//   o_ovf       displayed value is over-range
//   o_busy      BCD conversion in progress
module fnd_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int MAX_VAL  = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_blank_lz,
  input  logic [13:0] i_value,
  input  logic [3:0]  i_dp,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_data,
  output logic        o_ovf,
  output logic        o_busy
);
  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e        state_q, state_d;
  // {bcd[15:0], bin[13:0]} double-dabble working register
  logic [29:0]   sh_q, sh_d, adj;
  logic [3:0]    bit_q, bit_d;
  logic [13:0]   last_q, last_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          ovf_q, ovf_d, busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    cur_nib;
  logic          lz;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 8'hC0;
      4'd1: glyph = 8'hF9;
      4'd2: glyph = 8'hA4;
      4'd3: glyph = 8'hB0;
      4'd4: glyph = 8'h99;
      4'd5: glyph = 8'h92;
      4'd6: glyph = 8'h82;
      4'd7: glyph = 8'hF8;
      4'd8: glyph = 8'h80;
      4'd9: glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // ---------------- conversion FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- conversion FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_value != last_q) state_d = S_SHIFT;
      S_SHIFT: if (bit_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // add-3 on every BCD nibble that would overflow on the next shift
  always_comb begin
    adj = sh_q;
    for (int k = 0; k < 4; k++)
      if (sh_q[14+4*k +: 4] >= 4'd5) adj[14+4*k +: 4] = sh_q[14+4*k +: 4] + 4'd3;
  end

  // ---------------- conversion FSM: outputs / datapath next values
  always_comb begin
    sh_d   = sh_q;
    bit_d  = bit_q;
    last_d = last_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    case (state_q)
      S_IDLE: if (i_value != last_q) begin
        sh_d   = {16'd0, i_value};
        last_d = i_value;
        bit_d  = 4'd13;
        busy_d = 1'b1;
      end
      S_SHIFT: begin
        sh_d  = {adj[28:0], 1'b0};
        bit_d = bit_q - 4'd1;
      end
      S_DONE: begin
        busy_d = 1'b0;
        // over-range keeps the old digits; only the dash pattern shows
        if (int'({18'd0, last_q}) > MAX_VAL) ovf_d = 1'b1;
        else begin
          bcd_d = sh_q[29:14];
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---------------- scan timing and segment output
  always_comb begin
    cnt_d = (cnt_q == CW'(SCAN_DIV - 1)) ? '0 : cnt_q + CW'(1);
    dig_d = (cnt_q == CW'(SCAN_DIV - 1)) ? dig_q + 2'd1 : dig_q;

    cur_nib = bcd_q[{dig_q, 2'b00} +: 4];
    // blank digit n>0 when it and every higher digit are zero
    lz = i_blank_lz && (dig_q != 2'd0) && ((bcd_q >> {dig_q, 2'b00}) == 16'd0);

    com_d  = 4'hF;
    data_d = 8'hFF;
    if (i_en) begin
      com_d = ~(4'b0001 << dig_q);
      if (ovf_q)   data_d = 8'hBF;
      else if (lz) data_d = 8'hFF;
      else         data_d = glyph(cur_nib);
      if (i_dp[dig_q]) data_d[7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      bit_q  <= '0;
      last_q <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dig_q  <= '0;
      com_q  <= 4'hF;
      data_q <= 8'hFF;
    end else begin
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      last_q <= last_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      com_q  <= com_d;
      data_q <= data_d;
    end
  end

  assign o_fnd_com  = com_q;
  assign o_fnd_data = data_q;
  assign o_ovf      = ovf_q;
  assign o_busy     = busy_q;

endmodule
